// File: rtl/adc_burst_decoder.sv
// adc_burst_decoder: parses the ADC capture beat stream into bursts, accumulates
// per-burst statistics (beat count, channel peaks, below-trigger flag) and emits
// a two-word summary record per burst through an internal FIFO.
// Optional feature macro: ADC_BURST_DECODER_TIMEOUT_EN enables the in-burst idle
// timeout close (sets the trunc bit of the record).
module adc_burst_decoder #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        nclear,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] bursts_count,
    output logic [31:0] dropped_beats,
    output logic        busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = CntW + 1;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IDLE_TIMEOUT < 2)
    begin : g_param_check
        $error("adc_burst_decoder: invalid FIFO_DEPTH or IDLE_TIMEOUT");
    end

    typedef enum logic [0:0] {StIdle, StInBurst} state_e;

    // Burst accumulator state
    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [14:0] peak_a_q, peak_a_d;
    logic [14:0] peak_b_q, peak_b_d;
    logic        detrig_q, detrig_d;
    logic [15:0] bursts_q, bursts_d;
    logic [31:0] dropped_q, dropped_d;

    // Closed record waiting one cycle before entering the FIFO
    logic        rec_valid_q, rec_valid_d;
    logic [63:0] rec_q, rec_d;

    // Summary FIFO
    logic [63:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic            fifo_wr, fifo_pop;

    // Output serializer
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic [31:0] word1_q, word1_d;

    logic            tready_q, tready_d;
    logic [OccW-1:0] occ_d;

    // Beat decode
    logic        beat_acc, beat_end, beat_b31;
    logic [14:0] beat_a, beat_b;
    logic [15:0] acc_count;
    logic [14:0] acc_a, acc_b;
    logic        acc_det;
    logic        close_beat, close_timeout;

    assign beat_acc = s_axis_tvalid & tready_q;
    assign beat_end = s_axis_tlast | s_axis_tdata[30];
    assign beat_b31 = s_axis_tdata[31];
    assign beat_a   = s_axis_tdata[29:15];
    assign beat_b   = s_axis_tdata[14:0];

`ifdef ADC_BURST_DECODER_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
    logic [IdleW-1:0] idle_q, idle_d;

    // Idle counter register; only advances while inside a burst
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Accumulator values if the current beat is merged into the burst
    always_comb begin
        if (state_q == StIdle) begin
            acc_count = 16'd1;
            acc_a     = beat_a;
            acc_b     = beat_b;
            acc_det   = beat_b31;
        end else begin
            acc_count = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            acc_a     = (beat_a > peak_a_q) ? beat_a : peak_a_q;
            acc_b     = (beat_b > peak_b_q) ? beat_b : peak_b_q;
            acc_det   = detrig_q | beat_b31;
        end
    end

    // Burst FSM next state, counters and record capture
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        peak_a_d      = peak_a_q;
        peak_b_d      = peak_b_q;
        detrig_d      = detrig_q;
        bursts_d      = bursts_q;
        dropped_d     = dropped_q;
        close_beat    = 1'b0;
        close_timeout = 1'b0;
`ifdef ADC_BURST_DECODER_TIMEOUT_EN
        idle_d        = idle_q;
`endif
        if (!nclear) begin
            state_d   = StIdle;
            bursts_d  = '0;
            dropped_d = '0;
`ifdef ADC_BURST_DECODER_TIMEOUT_EN
            idle_d    = '0;
`endif
        end else begin
            if (s_axis_tvalid && !tready_q && dropped_q != 32'hFFFF_FFFF) begin
                dropped_d = dropped_q + 32'd1;
            end
            if (beat_acc) begin
                count_d  = acc_count;
                peak_a_d = acc_a;
                peak_b_d = acc_b;
                detrig_d = acc_det;
`ifdef ADC_BURST_DECODER_TIMEOUT_EN
                idle_d   = '0;
`endif
                if (beat_end) begin
                    close_beat = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StInBurst;
                end
            end
`ifdef ADC_BURST_DECODER_TIMEOUT_EN
            else if (state_q == StInBurst) begin
                // This edge completes the IDLE_TIMEOUT-th idle cycle
                if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
                    close_timeout = 1'b1;
                    state_d       = StIdle;
                    idle_d        = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
`endif
            if (close_beat || close_timeout) begin
                bursts_d = bursts_q + 16'd1;
            end
        end
        rec_valid_d = close_beat | close_timeout;
        if (close_timeout) begin
            rec_d = {bursts_q, count_q, 1'b1, peak_a_q, detrig_q, peak_b_q};
        end else begin
            rec_d = {bursts_q, acc_count, 1'b0, acc_a, acc_det, acc_b};
        end
    end

    // Burst state and counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            count_q     <= '0;
            peak_a_q    <= '0;
            peak_b_q    <= '0;
            detrig_q    <= 1'b0;
            bursts_q    <= '0;
            dropped_q   <= '0;
            rec_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            peak_a_q    <= peak_a_d;
            peak_b_q    <= peak_b_d;
            detrig_q    <= detrig_d;
            bursts_q    <= bursts_d;
            dropped_q   <= dropped_d;
            rec_valid_q <= rec_valid_d;
            rec_q       <= rec_d;
        end
    end

    assign fifo_wr  = rec_valid_q;
    // Pop when the serializer is empty or is completing word1 this cycle
    assign fifo_pop = (fifo_cnt_q != '0) && (!m_valid_q || (m_axis_tready && m_last_q));

    // FIFO occupancy bookkeeping
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_wr && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge aclk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= rec_q;
        end
    end

    // Serializer: word0 on load, word1 after word0 handshake
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        word1_d   = word1_q;
        if (m_valid_q && m_axis_tready) begin
            if (!m_last_q) begin
                m_data_d = word1_q;
                m_last_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        end
        if (fifo_pop) begin
            m_valid_d = 1'b1;
            m_data_d  = mem_q[rd_ptr_q][63:32];
            word1_d   = mem_q[rd_ptr_q][31:0];
            m_last_d  = 1'b0;
        end
    end

    // Records held anywhere downstream of the accumulator count against capacity;
    // one slot stays free for a record that closes while ready is still high.
    always_comb begin
        occ_d    = OccW'(fifo_cnt_d) + OccW'(m_valid_d) + OccW'(rec_valid_d);
        tready_d = (occ_d <= OccW'(FIFO_DEPTH - 2));
    end

    // Serializer and input-ready registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            word1_q   <= '0;
            tready_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            word1_q   <= word1_d;
            tready_q  <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign bursts_count  = bursts_q;
    assign dropped_beats = dropped_q;
    assign busy          = (state_q == StInBurst);

endmodule

// File: tb/tb_adc_burst_decoder.sv
// Directed bench for adc_burst_decoder (FIFO_DEPTH=8, IDLE_TIMEOUT=16).
module tb_adc_burst_decoder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        nclear;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] bursts_count;
    logic [31:0] dropped_beats;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [32:0] outq[$];

    adc_burst_decoder #(
        .FIFO_DEPTH   (8),
        .IDLE_TIMEOUT (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .nclear        (nclear),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .bursts_count  (bursts_count),
        .dropped_beats (dropped_beats),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    // Capture accepted output words as {tlast, tdata}
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            outq.push_back({m_axis_tlast, m_axis_tdata});
        end
    end

    function automatic logic [31:0] mk(input logic b31, input logic b30,
                                       input logic [14:0] a, input logic [14:0] b);
        return {b31, b30, a, b};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic clr();
        nclear = 1'b0;
        tick();
        nclear = 1'b1;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && outq.size() < n; i++) begin
            tick();
        end
        chk(tag, 64'(outq.size() >= n), 64'd1);
    endtask

    initial begin
        aresetn       = 1'b0;
        nclear        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        aresetn = 1'b1;
        tick();
        chk("rel_tready", 64'(s_axis_tready), 64'd1);
        chk("rel_mdata", 64'({m_axis_tlast, m_axis_tdata}), 64'd0);
        chk("rel_counts", 64'({bursts_count, dropped_beats}), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);

        // Four-beat burst, bit31 on second beat
        beat(mk(1'b0, 1'b0, 15'h0100, 15'h0010), 1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        beat(mk(1'b1, 1'b0, 15'h0101, 15'h0010), 1'b0);
        beat(mk(1'b0, 1'b0, 15'h0102, 15'h0010), 1'b0);
        beat(mk(1'b0, 1'b0, 15'h0103, 15'h0010), 1'b1);
        chk("t1_lat_t1", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("t1_lat_t2", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("t1_w0_valid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_w0", 64'({m_axis_tlast, m_axis_tdata}), {31'd0, 1'b0, 32'h0000_0004});
        tick();
        chk("t1_w1", 64'({m_axis_tlast, m_axis_tdata}), {31'd0, 1'b1, 32'h0103_8010});
        tick();
        chk("t1_drained", 64'(m_axis_tvalid), 64'd0);
        chk("t1_bursts", 64'(bursts_count), 64'd1);
        chk("t1_nwords", 64'(outq.size()), 64'd2);

        // Three one-beat bursts back to back after a clear
        clr();
        chk("t2_clr", 64'(bursts_count), 64'd0);
        outq.delete();
        for (int i = 0; i < 3; i++) begin
            beat(mk(1'b0, 1'b0, 15'(i + 1), 15'(2 * i)), 1'b1);
        end
        wait_words("t2_wait", 6, 40);
        for (int i = 0; i < 3; i++) begin
            if (outq.size() >= 2 * i + 2) begin
                chk("t2_w0", 64'(outq[2 * i]), {31'd0, 1'b0, 16'(i), 16'd1});
                chk("t2_w1", 64'(outq[2 * i + 1]), {31'd0, 1'b1, 1'b0, 15'(i + 1), 1'b0,
                                                    15'(2 * i)});
            end
        end
        chk("t2_bursts", 64'(bursts_count), 64'd3);
        chk("t2_dropped", 64'(dropped_beats), 64'd0);

        // Long burst: count saturates, peaks at fixed positions
        clr();
        outq.delete();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i <= 70000; i++) begin
            s_axis_tdata = mk(1'b0, 1'b0,
                              (i == 12345) ? 15'h6ABC : 15'(i & 32'hFFF),
                              (i == 50000) ? 15'h7123 : 15'h0055);
            s_axis_tlast = (i == 70000);
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_words("t3_wait", 2, 20);
        if (outq.size() >= 2) begin
            chk("t3_w0", 64'(outq[0]), {31'd0, 1'b0, 32'h0000_FFFF});
            chk("t3_w1", 64'(outq[1]), {31'd0, 1'b1, 32'h6ABC_7123});
        end

        // Two beats then silence
        clr();
        outq.delete();
        beat(mk(1'b0, 1'b0, 15'h0200, 15'h0001), 1'b0);
        beat(mk(1'b0, 1'b0, 15'h0300, 15'h0002), 1'b0);
`ifdef ADC_BURST_DECODER_TIMEOUT_EN
        repeat (15) tick();
        chk("t4_busy_pre", 64'(busy), 64'd1);
        tick();
        chk("t4_busy_post", 64'(busy), 64'd0);
        chk("t4_bursts", 64'(bursts_count), 64'd1);
        wait_words("t4_wait", 2, 20);
        if (outq.size() >= 2) begin
            chk("t4_w0", 64'(outq[0]), {31'd0, 1'b0, 32'h0000_0002});
            chk("t4_w1", 64'(outq[1]), {31'd0, 1'b1, 32'h8300_0002});
        end
`else
        repeat (40) tick();
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_norec", 64'(outq.size()), 64'd0);
        chk("t4_bursts", 64'(bursts_count), 64'd0);
        clr();
        chk("t4_clr_busy", 64'(busy), 64'd0);
`endif

        // Consumer stalled: 20 one-beat bursts offered
        clr();
        repeat (4) tick();
        outq.delete();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = mk(1'b0, 1'b0, 15'(i), 15'(i));
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("t5_tready", 64'(s_axis_tready), 64'd0);
        chk("t5_dropped", 64'(dropped_beats), 64'd13);
        chk("t5_bursts", 64'(bursts_count), 64'd7);
        chk("t5_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
            {30'd0, 1'b1, 1'b0, 32'h0000_0001});
        repeat (3) tick();
        chk("t5_stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
            {30'd0, 1'b1, 1'b0, 32'h0000_0001});
        m_axis_tready = 1'b1;
        wait_words("t5_wait", 14, 60);
        for (int i = 0; i < 7; i++) begin
            if (outq.size() >= 2 * i + 2) begin
                chk("t5_w0", 64'(outq[2 * i]), {31'd0, 1'b0, 16'(i), 16'd1});
                chk("t5_w1", 64'(outq[2 * i + 1]), {31'd0, 1'b1, 1'b0, 15'(i), 1'b0,
                                                    15'(i)});
            end
        end
        tick();
        chk("t5_tready_back", 64'(s_axis_tready), 64'd1);

        // Clear in the middle of a burst
        beat(mk(1'b0, 1'b0, 15'h0009, 15'h0009), 1'b0);
        beat(mk(1'b0, 1'b0, 15'h000A, 15'h0009), 1'b0);
        chk("t6_busy", 64'(busy), 64'd1);
        clr();
        chk("t6_busy_clr", 64'(busy), 64'd0);
        chk("t6_counts", 64'({bursts_count, dropped_beats}), 64'd0);
        outq.delete();
        beat(mk(1'b0, 1'b0, 15'h0005, 15'h0006), 1'b1);
        wait_words("t6_wait", 2, 20);
        repeat (5) tick();
        chk("t6_nwords", 64'(outq.size()), 64'd2);
        if (outq.size() >= 2) begin
            chk("t6_w0", 64'(outq[0]), {31'd0, 1'b0, 32'h0000_0001});
            chk("t6_w1", 64'(outq[1]), {31'd0, 1'b1, 32'h0005_0006});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
